// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_arbiter
//  Purpose  : Frame-locked round-robin arbiter sharing one 8N1 transmitter.
//  Revision : 1.0
// ============================================================================
module serial_tx_arbiter #(
    parameter int NumPorts = 4,
    parameter int PortIdxW = $clog2(NumPorts)
) (
    input  logic                  iClock,
    input  logic                  iResetN,
    input  logic [NumPorts-1:0]   iReqValid,
    input  logic [8*NumPorts-1:0] iReqData,
    input  logic [NumPorts-1:0]   iReqLast,
    output logic [NumPorts-1:0]   oReqAck,
    output logic [7:0]            oTxData,
    output logic                  oTxSend,
    input  logic                  iTxReady,
    output logic                  oBusy,
    output logic [PortIdxW-1:0]   oOwner
);

    typedef enum logic [1:0] {
        sIdle  = 2'd0,
        sSend  = 2'd1,
        sGuard = 2'd2
    } state_t;

    state_t                r_state,    w_state;
    logic [PortIdxW-1:0]   r_owner,    w_owner;
    logic [PortIdxW-1:0]   r_ptr,      w_ptr;
    logic                  r_busy,     w_busy;
    logic                  r_lastSeen, w_lastSeen;
    logic [7:0]            r_txData,   w_txData;
    logic                  r_txSend,   w_txSend;
    logic [NumPorts-1:0]   r_ack,      w_ack;

    logic                  w_found;
    logic [PortIdxW-1:0]   w_sel;
    logic [PortIdxW-1:0]   w_cand;
    logic                  w_candOk;

    function automatic logic [PortIdxW-1:0] wrapIdx(input int unsigned v);
        if (v >= int'(NumPorts))
            return PortIdxW'(v - int'(NumPorts));
        return PortIdxW'(v);
    endfunction

    // First valid port at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (!w_found && iReqValid[wrapIdx(int'(r_ptr) + i)]) begin
                w_found = 1'b1;
                w_sel   = wrapIdx(int'(r_ptr) + i);
            end
        end
    end

    // A fresh grant may send in the same cycle it locks.
    assign w_cand   = r_busy ? r_owner : w_sel;
    assign w_candOk = r_busy ? iReqValid[r_owner] : w_found;

    always_comb begin
        w_state    = r_state;
        w_owner    = r_owner;
        w_ptr      = r_ptr;
        w_busy     = r_busy;
        w_lastSeen = r_lastSeen;
        w_txData   = r_txData;
        w_txSend   = 1'b0;
        w_ack      = '0;
        case (r_state)
            sIdle: begin
                if (!r_busy && w_found) begin
                    w_owner = w_sel;
                    w_busy  = 1'b1;
                end
                if (w_candOk && iTxReady) begin
                    w_txData      = iReqData[{w_cand, 3'b000} +: 8];
                    w_txSend      = 1'b1;
                    w_ack[w_cand] = 1'b1;
                    w_lastSeen    = iReqLast[w_cand];
                    w_state       = sSend;
                end
            end
            sSend: begin
                if (r_lastSeen) begin
                    w_busy = 1'b0;
                    w_ptr  = wrapIdx(int'(r_owner) + 1);
                end
                w_state = sGuard;
            end
            sGuard: begin
                // Gives the transmitter a cycle to drop ready before re-sampling it.
                w_state = sIdle;
            end
            default: w_state = sIdle;
        endcase
    end

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            r_state    <= sIdle;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_busy     <= 1'b0;
            r_lastSeen <= 1'b0;
            r_txData   <= '0;
            r_txSend   <= 1'b0;
            r_ack      <= '0;
        end else begin
            r_state    <= w_state;
            r_owner    <= w_owner;
            r_ptr      <= w_ptr;
            r_busy     <= w_busy;
            r_lastSeen <= w_lastSeen;
            r_txData   <= w_txData;
            r_txSend   <= w_txSend;
            r_ack      <= w_ack;
        end
    end

    assign oReqAck = r_ack;
    assign oTxData = r_txData;
    assign oTxSend = r_txSend;
    assign oBusy   = r_busy;
    assign oOwner  = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx_arbiter
//  Purpose  : Scoreboard bench for serial_tx_arbiter with a simple 8N1 tx model.
//  Revision : 1.0
// ============================================================================
module tb_serial_tx_arbiter;

    localparam int NP    = 4;
    localparam int TXLEN = 28;

    logic            iClock = 1'b0;
    logic            iResetN;
    logic [NP-1:0]   iReqValid;
    logic [8*NP-1:0] iReqData;
    logic [NP-1:0]   iReqLast;
    logic [NP-1:0]   oReqAck;
    logic [7:0]      oTxData;
    logic            oTxSend;
    logic            iTxReady;
    logic            oBusy;
    logic [1:0]      oOwner;

    always #5 iClock = ~iClock;

    serial_tx_arbiter #(.NumPorts(NP)) dut (
        .iClock   (iClock),
        .iResetN  (iResetN),
        .iReqValid(iReqValid),
        .iReqData (iReqData),
        .iReqLast (iReqLast),
        .oReqAck  (oReqAck),
        .oTxData  (oTxData),
        .oTxSend  (oTxSend),
        .iTxReady (iTxReady),
        .oBusy    (oBusy),
        .oOwner   (oOwner)
    );

    // Transmitter: ready drops after a send and returns inside the stop bit.
    logic txAlwaysReady;
    int   txCnt;
    assign iTxReady = txAlwaysReady || (txCnt == 0);
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN)                txCnt <= 0;
        else if (oTxSend && iTxReady) txCnt <= TXLEN;
        else if (txCnt > 0)          txCnt <= txCnt - 1;
    end

    int checks = 0;
    int fails  = 0;
    logic [10:0] expQ[$];
    int   sendCycles[$];
    logic [8:0] pBuf [NP][16];
    int   pHead [NP];
    int   pTail [NP];
    logic hold  [NP];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pushByte(input int p, input logic [7:0] d, input logic last);
        pBuf[p][pTail[p] % 16] = {last, d};
        pTail[p]++;
    endtask

    task automatic expSend(input int p, input logic [7:0] d);
        expQ.push_back({3'(p), d});
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (expQ.size() != 0 && n < maxc) begin
            @(negedge iClock);
            n++;
        end
        chk("drainRemaining", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic clearStim();
        for (int p = 0; p < NP; p++) begin
            pHead[p] = 0;
            pTail[p] = 0;
            hold[p]  = 1'b0;
            for (int j = 0; j < 16; j++) pBuf[p][j] = '0;
        end
        expQ.delete();
    endtask

    // Requester driver: advance on ack, present head byte while not held.
    initial begin
        iReqValid = '0;
        iReqData  = '0;
        iReqLast  = '0;
        forever begin
            @(negedge iClock);
            for (int p = 0; p < NP; p++) begin
                if (oReqAck[p]) pHead[p]++;
                iReqValid[p]       = (pHead[p] != pTail[p]) && !hold[p];
                iReqData[8*p +: 8] = pBuf[p][pHead[p] % 16][7:0];
                iReqLast[p]        = pBuf[p][pHead[p] % 16][8];
            end
        end
    end

    // Monitor: every send is matched against the scoreboard.
    initial begin
        logic        prevReady = 1'b0;
        logic        prevSend  = 1'b0;
        int          cyc       = 0;
        logic [10:0] e;
        logic [NP-1:0] expAck;
        forever begin
            @(negedge iClock);
            cyc++;
            if (iResetN) begin
                if (oTxSend) begin
                    chk("sendTwoCycles", {31'd0, prevSend}, 0);
                    chk("sendWhileNotReady", {31'd0, prevReady}, 1);
                    sendCycles.push_back(cyc);
                    if (expQ.size() == 0) begin
                        chk("unexpectedSend", {24'd0, oTxData}, 32'hFFFF);
                    end else begin
                        e = expQ.pop_front();
                        expAck = '0;
                        expAck[e[9:8]] = 1'b1;
                        chk("txData", {24'd0, oTxData}, {24'd0, e[7:0]});
                        chk("owner", {30'd0, oOwner}, {29'd0, e[10:8]});
                        chk("ackOneHot", {28'd0, oReqAck}, {28'd0, expAck});
                        chk("busyDuringSend", {31'd0, oBusy}, 1);
                    end
                end else if (oReqAck != '0) begin
                    chk("ackWithoutSend", {28'd0, oReqAck}, 0);
                end
            end
            prevReady = iTxReady;
            prevSend  = oTxSend;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  n;
        int  lowCnt;
        logic found;

        iResetN = 1'b0;
        txAlwaysReady = 1'b0;
        clearStim();
        repeat (3) @(posedge iClock);
        @(negedge iClock);
        chk("rstTxSend", {31'd0, oTxSend}, 0);
        chk("rstAck",    {28'd0, oReqAck}, 0);
        chk("rstTxData", {24'd0, oTxData}, 0);
        chk("rstBusy",   {31'd0, oBusy}, 0);
        chk("rstOwner",  {30'd0, oOwner}, 0);
        iResetN = 1'b1;

        // Single-port three-byte frame on port 2, then pointer sits at 3.
        pushByte(2, 8'h41, 1'b0); pushByte(2, 8'h42, 1'b0); pushByte(2, 8'h43, 1'b1);
        expSend(2, 8'h41); expSend(2, 8'h42); expSend(2, 8'h43);
        drain(500);
        @(negedge iClock);
        chk("busyAfterLast", {31'd0, oBusy}, 0);
        chk("ownerHeld", {30'd0, oOwner}, 2);
        pushByte(0, 8'h50, 1'b1); pushByte(3, 8'h53, 1'b1);
        expSend(3, 8'h53); expSend(0, 8'h50);
        drain(500);

        // Fresh pointer: ports 0,1,3 rotate.
        iResetN = 1'b0;
        clearStim();
        @(negedge iClock);
        iResetN = 1'b1;
        pushByte(0, 8'hA0, 1'b1); pushByte(0, 8'hA1, 1'b1);
        pushByte(1, 8'hB0, 1'b1); pushByte(1, 8'hB1, 1'b1);
        pushByte(3, 8'hD0, 1'b1); pushByte(3, 8'hD1, 1'b1);
        expSend(0, 8'hA0); expSend(1, 8'hB0); expSend(3, 8'hD0);
        expSend(0, 8'hA1); expSend(1, 8'hB1); expSend(3, 8'hD1);
        drain(1000);

        // Lock: port 0 waits for port 1's whole frame.
        for (int k = 0; k < 4; k++) pushByte(1, 8'h10 + 8'(k), k == 3);
        for (int k = 0; k < 4; k++) expSend(1, 8'h10 + 8'(k));
        n = 0;
        while (expQ.size() > 3 && n < 500) begin
            @(posedge iClock);
            n++;
        end
        chk("lockFirstByteTimeout", {31'd0, (expQ.size() > 3)}, 0);
        pushByte(0, 8'h05, 1'b1);
        expSend(0, 8'h05);
        drain(1000);

        // Back-to-back with ready always high: 3-cycle send period.
        txAlwaysReady = 1'b1;
        sendCycles.delete();
        for (int k = 0; k < 5; k++) pushByte(2, 8'h60 + 8'(k), k == 4);
        for (int k = 0; k < 5; k++) expSend(2, 8'h60 + 8'(k));
        drain(200);
        chk("btbCount", sendCycles.size(), 5);
        for (int k = 1; k < sendCycles.size(); k++)
            chk("btbPeriod", sendCycles[k] - sendCycles[k-1], 3);

        // Reset during sSend of the second byte.
        pushByte(1, 8'h71, 1'b0); pushByte(1, 8'h72, 1'b0); pushByte(1, 8'h73, 1'b1);
        expSend(1, 8'h71);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge iClock);
            #1;
            if (oTxSend && oTxData == 8'h72) found = 1'b1;
        end
        chk("midFrameSendSeen", {31'd0, found}, 1);
        iResetN = 1'b0;
        #1;
        chk("asyncTxSend", {31'd0, oTxSend}, 0);
        chk("asyncAck",    {28'd0, oReqAck}, 0);
        chk("asyncTxData", {24'd0, oTxData}, 0);
        chk("asyncBusy",   {31'd0, oBusy}, 0);
        chk("asyncOwner",  {30'd0, oOwner}, 0);
        txAlwaysReady = 1'b0;
        clearStim();
        repeat (2) @(negedge iClock);
        iResetN = 1'b1;
        for (int p = 0; p < NP; p++) pushByte(p, 8'h80 + 8'(p), 1'b1);
        for (int p = 0; p < NP; p++) expSend(p, 8'h80 + 8'(p));
        drain(1000);

        // Owner stalls mid-frame while others wait.
        pushByte(2, 8'h90, 1'b0);
        expSend(2, 8'h90);
        drain(500);
        hold[2] = 1'b1;
        pushByte(2, 8'h91, 1'b0); pushByte(2, 8'h92, 1'b1);
        pushByte(0, 8'hE0, 1'b1); pushByte(1, 8'hE1, 1'b1);
        n = 0;
        lowCnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge iClock);
            if (oTxSend) n++;
            if (!oBusy) lowCnt++;
        end
        chk("stallNoSend", n, 0);
        chk("stallBusyLow", lowCnt, 0);
        chk("stallOwner", {30'd0, oOwner}, 2);
        expSend(2, 8'h91); expSend(2, 8'h92); expSend(0, 8'hE0); expSend(1, 8'hE1);
        hold[2] = 1'b0;
        drain(2000);

        repeat (5) @(negedge iClock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one 8N1 serial transmitter among NumPorts byte-stream requesters.
- Requesters hand over bytes with a valid/ack handshake and mark the final byte of each frame with Last.
- Grants go round-robin per frame: an owner keeps the transmitter until its Last byte is accepted, so frames from different requesters never interleave.
- Sits between the protocol/logging clients and the transmitter (iSend/iData/oReady side).

Parameters:
- NumPorts, 4, number of requesters (2..8).
- PortIdxW, $clog2(NumPorts), width of the owner index.

Ports:
- iClock  in  1  system clock, same clock as the transmitter.
- iResetN  in  1  asynchronous active-low reset.
- iReqValid  in  NumPorts  per-port byte valid; held until acked.
- iReqData  in  8*NumPorts  per-port byte; port k uses bits [8k+7:8k].
- iReqLast  in  NumPorts  per-port "this byte ends the frame"; qualified by iReqValid.
- oReqAck  out  NumPorts  one-cycle pulse on the port whose byte was handed to the transmitter.
- oTxData  out  8  byte to transmitter iData.
- oTxSend  out  1  transmitter iSend pulse.
- iTxReady  in  1  transmitter oReady.
- oBusy  out  1  a frame is locked (owner valid).
- oOwner  out  PortIdxW  index of the current/last owner.

Behaviour:
- Reset (async, iResetN=0): oReqAck=0, oTxSend=0, oTxData=0, oBusy=0, oOwner=0, state=sIdle, RR pointer=0 (port 0 has highest priority first).
- All outputs are registered.
- States: sIdle, sSend, sGuard.
- sIdle, no lock:
  - If any iReqValid, pick the first valid port at or after the RR pointer, wrapping modulo NumPorts.
  - Set owner=that port, oBusy=1 (lock).
- sIdle, locked, owner's iReqValid=1, iTxReady=1:
  - Next edge: oTxData<=owner data, oTxSend<=1, oReqAck[owner]<=1, LastSeen<=owner's iReqLast.
  - Go to sSend.
- Arbitration and the first send may happen in the same cycle: from sIdle with no lock, a valid request and iTxReady=1, the byte goes out on the next edge. Latency from request to oTxSend/ack is 1 cycle.
- sSend (oTxSend and ack high for exactly this one cycle; the transmitter samples it here):
  - Next edge: oTxSend<=0, oReqAck<=0, go to sGuard.
  - If LastSeen=1: clear the lock (oBusy<=0) and set the RR pointer to owner+1 (wrap to 0 after NumPorts-1).
- sGuard:
  - Lasts one cycle, ignores iTxReady, then returns to sIdle.
  - This guarantees the transmitter's ready drop is observed and no byte is sent twice.
- While locked, non-owner valids are ignored, including higher-priority ports. Owner valid low leaves the lock held indefinitely; there is no timeout.
- The owner may present its next byte while the previous stop bit is still in flight. iTxReady rises during the stop bit, so back-to-back bytes go out with no idle gap.
- iReqValid dropping without an ack is permitted. If it was the owner, the lock is still held.
- Minimum spacing between accepted bytes is 3 cycles (sIdle→sSend→sGuard). This meets the transmitter constraint since a byte lasts ≥3 clocks per bit.
- The ack fires only on a send. The requester must update data or valid in the cycle after the ack.
- oOwner holds its value after unlock until the next grant.
- Reset mid-frame: everything returns to reset values immediately. A byte already taken by the transmitter completes on the line independently.

Test Plan:
- Single port 2, 3-byte frame 0x41,0x42,0x43 (Last on 0x43), iTxReady modelled by a real transmitter:
  - Exactly 3 oTxSend pulses, each with the matching oTxData.
  - 3 acks on port 2 only.
  - oBusy falls after the 0x43 send.
  - Pointer=3.
- Ports 0,1,3 all valid with 1-byte frames, pointer=0:
  - Grant order 0,1,3,0,...
  - oOwner sequence matches.
  - No ack pulse on any other port.
- Lock test: port 1 in a 4-byte frame; port 0 asserts valid after byte 1:
  - Port 0 gets no ack until port 1's Last byte is accepted.
  - Port 0 is granted next.
- Back-to-back: owner valid continuously with iTxReady held 1 by the model:
  - oTxSend period is exactly 3 cycles.
  - No send while iTxReady=0.
  - oTxSend is never high for 2 consecutive cycles.
- Reset asserted during sSend of byte 2 of a frame:
  - Outputs are 0 asynchronously.
  - After release, port 0 wins when all ports are valid.
- Owner valid drops mid-frame for 50 cycles while other ports are valid:
  - No sends, oBusy stays 1.
  - When the owner resumes, its next byte is sent.
